// File: rtl/regfile_dump_pkg.sv
// Shared constants and state encoding for the register-file dump engine.
// States are plain 2-bit constants so older netlists and scripts keep matching them.
package regfile_dump_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int BYTE_W     = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_SEND = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Counter width that stays legal when a word is a single byte
  function automatic int cnt_width(input int num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_ser.sv
// Parallel-in/serial-out byte shifter: loads one register word and hands it out
// one byte at a time, least significant byte first.
module regfile_dump_ser
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last_byte
);

  localparam int NUM_BYTES = DATA_W / BYTE_W;
  localparam int CNT_W     = cnt_width(NUM_BYTES);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  byte_cnt;

  // Load wins over shift so a fresh word always restarts the byte count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shreg    <= load_data;
      byte_cnt <= '0;
    end else if (shift) begin
      shreg    <= shreg >> BYTE_W;
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  assign byte_out  = shreg[BYTE_W-1:0];
  assign last_byte = (byte_cnt == CNT_W'(NUM_BYTES - 1));

endmodule

// File: rtl/regfile_dump.sv
// Debug readout engine: walks a register range on a dedicated register-file read
// port and streams every word out as little-endian bytes over valid/ready.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              handshake;
  logic              last_byte;
  logic              at_last;

  assign handshake = (state == ST_SEND) && i_tx_ready;
  assign at_last   = (cur_addr == last_addr);

  // Abort overrides every other transition, including a start seen in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_start) state_nxt = (i_first_addr > i_last_addr) ? ST_DONE : ST_READ;
      ST_READ: state_nxt = ST_SEND;
      ST_SEND: if (handshake && last_byte) state_nxt = at_last ? ST_DONE : ST_READ;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (i_abort) state_nxt = ST_IDLE;
  end

  // cur_addr only advances when another register follows, so last_addr at the
  // top of the address space never overflows the counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      last_addr <= '0;
    end else begin
      state <= state_nxt;
      if (!i_abort) begin
        if ((state == ST_IDLE) && i_start) begin
          cur_addr  <= i_first_addr;
          last_addr <= i_last_addr;
        end else if (handshake && last_byte && !at_last) begin
          cur_addr <= cur_addr + ADDR_W'(1);
        end
      end
    end
  end

  regfile_dump_ser #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (state == ST_READ),
    .load_data (i_rf_data),
    .shift     (handshake),
    .byte_out  (o_tx_data),
    .last_byte (last_byte)
  );

  assign o_rf_addr  = (state == ST_IDLE) ? '0 : cur_addr;
  assign o_tx_valid = (state == ST_SEND);
  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_DONE);

endmodule
